pcm_dsp_slave: RTL and testbench

PCM_DSP_SLAVE -- requirements
Module: pcm_dsp_slave

---
 rtl/pcm_dsp_slave_pkg.sv | 43 ++++
 rtl/pcm_edge_sync.sv | 35 +++
 rtl/pcm_dsp_slave.sv | 188 ++++++++++++++++++
 tb/tb_pcm_dsp_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pcm_dsp_slave_pkg.sv
// Shared definitions for the DSP-mode PCM slave: register addresses,
// FSM states, sample-width encoding and small sample helpers.
package pcm_dsp_slave_pkg;

    localparam logic [7:0]  ADDR_CONFIG   = 8'h00;
    localparam logic [7:0]  ADDR_STATUS   = 8'h04;
    localparam logic [7:0]  ADDR_ERR_CLR  = 8'h08;
    localparam logic [31:0] UNMAPPED_DATA = 32'hdeadbabe;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LCH  = 3'd2,
        ST_RCH  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BPS_16 = 2'b00,
        BPS_20 = 2'b01,
        BPS_24 = 2'b10,
        BPS_32 = 2'b11
    } bps_t;

    function automatic logic [5:0] bps_bits(input bps_t b);
        case (b)
            BPS_16:  return 6'd16;
            BPS_20:  return 6'd20;
            BPS_24:  return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] sign_extend(input logic [31:0] v, input bps_t b);
        case (b)
            BPS_16:  return {{16{v[15]}}, v[15:0]};
            BPS_20:  return {{12{v[19]}}, v[19:0]};
            BPS_24:  return {{8{v[23]}}, v[23:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/pcm_edge_sync.sv
// Two-flop synchronizers for the serial pins; BCLK also gets an extra
// history flop so its rise/fall can be flagged as single-cycle pulses.
module pcm_edge_sync #(
    parameter int AUX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bclk,
    input  logic [AUX_W-1:0] aux,
    output logic [AUX_W-1:0] aux_sync,
    output logic             bclk_rise,
    output logic             bclk_fall
);

    logic [2:0] bclk_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bclk_pipe <= '0;
        else        bclk_pipe <= {bclk_pipe[1:0], bclk};
    end

    assign bclk_rise =  bclk_pipe[1] & ~bclk_pipe[2];
    assign bclk_fall = ~bclk_pipe[1] &  bclk_pipe[2];

    genvar gi;
    for (gi = 0; gi < AUX_W; gi++) begin : g_aux
        logic [1:0] pipe;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= {pipe[0], aux[gi]};
        end
        assign aux_sync[gi] = pipe[1];
    end

endmodule

// File: rtl/pcm_dsp_slave.sv
// DSP-mode PCM slave: receives and transmits one left/right sample pair per
// LRCK frame pulse, with a small local-bus register file for control/status.
module pcm_dsp_slave
    import pcm_dsp_slave_pkg::*;
#(
    parameter int LB_DATA_W  = 32,
    parameter int LB_ADDR_W  = 8,
    parameter int ERR_CNTR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lb_wr_en,
    input  logic                 lb_rd_en,
    input  logic [LB_ADDR_W-1:0] lb_addr,
    input  logic [LB_DATA_W-1:0] lb_wr_data,
    output logic                 lb_wr_valid,
    output logic                 lb_rd_valid,
    output logic [LB_DATA_W-1:0] lb_rd_data,
    input  logic                 PCM_BCLK,
    input  logic                 PCM_LRCK,
    input  logic                 PCM_DIN,
    output logic                 PCM_DOUT,
    output logic                 rx_pcm_valid,
    output logic [31:0]          rx_lpcm_data,
    output logic [31:0]          rx_rpcm_data,
    output logic                 tx_pcm_nxt,
    input  logic [31:0]          tx_lpcm_data,
    input  logic [31:0]          tx_rpcm_data
);

    logic       bclk_rise, bclk_fall, lrck, din;
    logic [1:0] aux_sync;

    pcm_edge_sync #(.AUX_W(2)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (PCM_BCLK),
        .aux       ({PCM_LRCK, PCM_DIN}),
        .aux_sync  (aux_sync),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    assign lrck = aux_sync[1];
    assign din  = aux_sync[0];

    logic                  en_reg;
    bps_t                  bps_cfg_reg, bps_frame_reg;
    logic [ERR_CNTR_W-1:0] err_cnt_reg;
    state_t                state_reg, state_next;
    logic [5:0]            bit_cnt_reg, n_bits;
    logic [4:0]            tx_idx;
    logic [31:0]           rx_shift_reg, rx_word, rx_left_reg, tx_left_reg, tx_right_reg;
    logic                  frame_start, short_err, sample_bit, last_left, last_right, bit_last;
    logic                  wr_config, wr_err_clr;
    logic [LB_DATA_W-1:0]  rd_word;

    // Frame length comes from the width latched at frame start, never the live config.
    assign n_bits   = bps_bits(bps_frame_reg);
    assign bit_last = (bit_cnt_reg == n_bits - 6'd1);
    assign tx_idx   = 5'(n_bits - 6'd1 - bit_cnt_reg);
    assign rx_word  = {rx_shift_reg[30:0], din};

    assign wr_config  = lb_wr_en && (lb_addr == LB_ADDR_W'(ADDR_CONFIG));
    assign wr_err_clr = lb_wr_en && (lb_addr == LB_ADDR_W'(ADDR_ERR_CLR));

    always_comb begin
        rd_word = '0;
        if (lb_addr == LB_ADDR_W'(ADDR_CONFIG)) begin
            rd_word[0]   = en_reg;
            rd_word[2:1] = bps_cfg_reg;
        end else if (lb_addr == LB_ADDR_W'(ADDR_STATUS)) begin
            rd_word[2:0]              = state_reg;
            rd_word[8 +: ERR_CNTR_W]  = err_cnt_reg;
        end else if (lb_addr != LB_ADDR_W'(ADDR_ERR_CLR)) begin
            rd_word = LB_DATA_W'(UNMAPPED_DATA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data  <= '0;
            en_reg      <= 1'b0;
            bps_cfg_reg <= BPS_16;
            err_cnt_reg <= '0;
        end else begin
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if (lb_rd_en) lb_rd_data <= rd_word;
            if (wr_config) begin
                en_reg      <= lb_wr_data[0];
                bps_cfg_reg <= bps_t'(lb_wr_data[2:1]);
            end
            // A clear wins over a simultaneous error increment.
            if (wr_err_clr)
                err_cnt_reg <= '0;
            else if (short_err && !(&err_cnt_reg))
                err_cnt_reg <= err_cnt_reg + ERR_CNTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        short_err   = 1'b0;
        sample_bit  = 1'b0;
        last_left   = 1'b0;
        last_right  = 1'b0;
        if (!en_reg) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_SYNC;
                ST_SYNC, ST_WAIT: begin
                    if (bclk_rise && lrck) begin
                        frame_start = 1'b1;
                        state_next  = ST_LCH;
                    end
                end
                ST_LCH, ST_RCH: begin
                    if (bclk_rise && lrck) begin
                        // Early frame pulse: drop the partial frame and restart here.
                        short_err   = 1'b1;
                        frame_start = 1'b1;
                        state_next  = ST_LCH;
                    end else if (bclk_rise) begin
                        sample_bit = 1'b1;
                        if (bit_last) begin
                            if (state_reg == ST_LCH) begin
                                last_left  = 1'b1;
                                state_next = ST_RCH;
                            end else begin
                                last_right = 1'b1;
                                state_next = ST_WAIT;
                            end
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pcm_nxt    <= 1'b0;
            rx_pcm_valid  <= 1'b0;
            bps_frame_reg <= BPS_16;
            tx_left_reg   <= '0;
            tx_right_reg  <= '0;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_left_reg   <= '0;
            rx_lpcm_data  <= '0;
            rx_rpcm_data  <= '0;
            PCM_DOUT      <= 1'b0;
        end else begin
            tx_pcm_nxt   <= frame_start;
            rx_pcm_valid <= last_right;
            if (frame_start) begin
                bps_frame_reg <= bps_cfg_reg;
                tx_left_reg   <= tx_lpcm_data;
                tx_right_reg  <= tx_rpcm_data;
                bit_cnt_reg   <= '0;
            end else if (sample_bit) begin
                rx_shift_reg <= rx_word;
                bit_cnt_reg  <= bit_last ? 6'd0 : bit_cnt_reg + 6'd1;
            end
            if (last_left) rx_left_reg <= rx_word;
            if (last_right) begin
                rx_lpcm_data <= sign_extend(rx_left_reg, bps_frame_reg);
                rx_rpcm_data <= sign_extend(rx_word, bps_frame_reg);
            end
            if (state_next != ST_LCH && state_next != ST_RCH)
                PCM_DOUT <= 1'b0;
            else if (bclk_fall)
                PCM_DOUT <= (state_reg == ST_LCH) ? tx_left_reg[tx_idx] : tx_right_reg[tx_idx];
        end
    end

endmodule

// File: tb/tb_pcm_dsp_slave.sv
// Directed bench for pcm_dsp_slave: plays a DSP-mode master on the serial
// pins and checks received samples, transmitted bits and register behaviour.
module tb_pcm_dsp_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lb_wr_en = 1'b0, lb_rd_en = 1'b0;
    logic [7:0]  lb_addr = '0;
    logic [31:0] lb_wr_data = '0;
    logic        lb_wr_valid, lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        PCM_BCLK = 1'b0, PCM_LRCK = 1'b0, PCM_DIN = 1'b0;
    logic        PCM_DOUT;
    logic        rx_pcm_valid, tx_pcm_nxt;
    logic [31:0] rx_lpcm_data, rx_rpcm_data;
    logic [31:0] tx_lpcm_data = '0, tx_rpcm_data = '0;

    pcm_dsp_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lb_wr_en     (lb_wr_en),
        .lb_rd_en     (lb_rd_en),
        .lb_addr      (lb_addr),
        .lb_wr_data   (lb_wr_data),
        .lb_wr_valid  (lb_wr_valid),
        .lb_rd_valid  (lb_rd_valid),
        .lb_rd_data   (lb_rd_data),
        .PCM_BCLK     (PCM_BCLK),
        .PCM_LRCK     (PCM_LRCK),
        .PCM_DIN      (PCM_DIN),
        .PCM_DOUT     (PCM_DOUT),
        .rx_pcm_valid (rx_pcm_valid),
        .rx_lpcm_data (rx_lpcm_data),
        .rx_rpcm_data (rx_rpcm_data),
        .tx_pcm_nxt   (tx_pcm_nxt),
        .tx_lpcm_data (tx_lpcm_data),
        .tx_rpcm_data (tx_rpcm_data)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          rx_cnt = 0, tx_cnt = 0, rx0, tx0;
    logic        mdout;
    logic [31:0] gl, gr, rd, vl, vr;

    always @(negedge clk) begin
        if (rx_pcm_valid) rx_cnt++;
        if (tx_pcm_nxt)   tx_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        lb_wr_en = 1'b1; lb_addr = addr; lb_wr_data = data;
        @(negedge clk);
        lb_wr_en = 1'b0;
        check("wr_valid", 32'(lb_wr_valid), 32'd1);
        $display("LB WR addr=%h data=%h", addr, data);
    endtask

    task automatic lb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        lb_rd_en = 1'b1; lb_addr = addr;
        @(negedge clk);
        lb_rd_en = 1'b0;
        check("rd_valid", 32'(lb_rd_valid), 32'd1);
        data = lb_rd_data;
        $display("LB RD addr=%h data=%h", addr, data);
    endtask

    // One BCLK period of 8 clk: master changes LRCK/DIN on the fall and
    // samples PCM_DOUT on the rise.
    task automatic pbit(input logic lrck, input logic d);
        @(negedge clk);
        PCM_BCLK = 1'b0; PCM_LRCK = lrck; PCM_DIN = d;
        repeat (3) @(negedge clk);
        @(negedge clk);
        PCM_BCLK = 1'b1; mdout = PCM_DOUT;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame(input int n, input logic [31:0] l, input logic [31:0] r);
        gl = '0; gr = '0;
        pbit(1'b1, 1'b0);
        for (int k = n - 1; k >= 0; k--) begin pbit(1'b0, l[k]); gl[k] = mdout; end
        for (int k = n - 1; k >= 0; k--) begin pbit(1'b0, r[k]); gr[k] = mdout; end
        pbit(1'b0, 1'b0);
        check("dout_wait", 32'(mdout), 32'd0);
        pbit(1'b0, 1'b0);
        $display("FRAME n=%0d sent L=%h R=%h got_tx L=%h R=%h rx L=%h R=%h",
                 n, l, r, gl, gr, rx_lpcm_data, rx_rpcm_data);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_valid", 32'(lb_wr_valid), 32'd0);
        check("rst_rd_valid", 32'(lb_rd_valid), 32'd0);
        check("rst_rd_data", lb_rd_data, 32'd0);
        check("rst_dout", 32'(PCM_DOUT), 32'd0);
        check("rst_rx_valid", 32'(rx_pcm_valid), 32'd0);
        check("rst_tx_nxt", 32'(tx_pcm_nxt), 32'd0);
        check("rst_rx_l", rx_lpcm_data, 32'd0);
        check("rst_rx_r", rx_rpcm_data, 32'd0);
        rst_n = 1'b1;

        lb_read(8'h00, rd); check("cfg_reset", rd, 32'h0);
        lb_read(8'h0C, rd); check("unmapped", rd, 32'hdeadbabe);
        lb_write(8'h00, 32'h1);
        lb_read(8'h04, rd); check("status_sync", rd, 32'h1);
        lb_write(8'h04, 32'hFFFF);
        lb_read(8'h04, rd); check("status_ro", rd, 32'h1);

        // 16-bit loopback
        tx_lpcm_data = 32'h1234; tx_rpcm_data = 32'hA5C3;
        rx0 = rx_cnt; tx0 = tx_cnt;
        frame(16, 32'h8001, 32'h7FFF);
        check("rx16_l", rx_lpcm_data, 32'hFFFF8001);
        check("rx16_r", rx_rpcm_data, 32'h00007FFF);
        check("rx16_cnt", 32'(rx_cnt - rx0), 32'd1);
        check("tx16_nxt", 32'(tx_cnt - tx0), 32'd1);
        check("tx16_l", gl, 32'h1234);
        check("tx16_r", gr, 32'hA5C3);

        // 24-bit transmit
        lb_write(8'h00, 32'h5);
        tx_lpcm_data = 32'h00ABCDEF; tx_rpcm_data = 32'h00123456;
        rx0 = rx_cnt; tx0 = tx_cnt;
        frame(24, 32'h800000, 32'h7FFFFF);
        check("tx24_l", gl, 32'h00ABCDEF);
        check("tx24_r", gr, 32'h00123456);
        check("tx24_nxt", 32'(tx_cnt - tx0), 32'd1);
        check("rx24_l", rx_lpcm_data, 32'hFF800000);
        check("rx24_r", rx_rpcm_data, 32'h007FFFFF);
        check("rx24_cnt", 32'(rx_cnt - rx0), 32'd1);

        // short frame after 10 left bits
        lb_write(8'h00, 32'h1);
        rx0 = rx_cnt;
        pbit(1'b1, 1'b0);
        repeat (10) pbit(1'b0, 1'b1);
        frame(16, 32'h0005, 32'hFFFE);
        lb_read(8'h04, rd); check("short_status", rd, 32'h00000104);
        check("short_cnt", 32'(rx_cnt - rx0), 32'd1);
        check("short_rx_l", rx_lpcm_data, 32'h00000005);
        check("short_rx_r", rx_rpcm_data, 32'hFFFFFFFE);

        // width change mid-frame takes effect on the next frame
        tx_lpcm_data = 32'hCAFEF00D; tx_rpcm_data = 32'h0BADBEEF;
        rx0 = rx_cnt;
        vl = 32'hC003; vr = 32'h1001;
        pbit(1'b1, 1'b0);
        for (int k = 15; k >= 8; k--) pbit(1'b0, vl[k]);
        lb_write(8'h00, 32'h7);
        for (int k = 7; k >= 0; k--) pbit(1'b0, vl[k]);
        for (int k = 15; k >= 0; k--) pbit(1'b0, vr[k]);
        pbit(1'b0, 1'b0); pbit(1'b0, 1'b0);
        check("mid_rx_l", rx_lpcm_data, 32'hFFFFC003);
        check("mid_rx_r", rx_rpcm_data, 32'h00001001);
        frame(32, 32'h80000001, 32'h12345678);
        check("rx32_l", rx_lpcm_data, 32'h80000001);
        check("rx32_r", rx_rpcm_data, 32'h12345678);
        check("tx32_l", gl, 32'hCAFEF00D);
        check("tx32_r", gr, 32'h0BADBEEF);
        check("mid_cnt", 32'(rx_cnt - rx0), 32'd2);

        // disable mid-left-channel
        tx_lpcm_data = 32'hFFFFFFFF;
        pbit(1'b1, 1'b0);
        repeat (3) pbit(1'b0, 1'b0);
        check("dis_dout_before", 32'(PCM_DOUT), 32'd1);
        lb_write(8'h00, 32'h6);
        lb_read(8'h04, rd); check("dis_status", rd, 32'h00000100);
        check("dis_dout", 32'(PCM_DOUT), 32'd0);

        // reset mid-right-channel
        lb_write(8'h00, 32'h1);
        tx_rpcm_data = 32'h0000FFFF;
        pbit(1'b1, 1'b0);
        repeat (16) pbit(1'b0, 1'b0);
        repeat (5) pbit(1'b0, 1'b0);
        check("rst_dout_before", 32'(PCM_DOUT), 32'd1);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("arst_dout", 32'(PCM_DOUT), 32'd0);
        check("arst_rx_l", rx_lpcm_data, 32'd0);
        check("arst_rx_r", rx_rpcm_data, 32'd0);
        check("arst_rd_data", lb_rd_data, 32'd0);
        check("arst_rx_valid", 32'(rx_pcm_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        lb_read(8'h00, rd); check("arst_cfg", rd, 32'h0);
        lb_read(8'h04, rd); check("arst_status", rd, 32'h0);

        // error counter saturation and clear
        lb_write(8'h00, 32'h1);
        rx0 = rx_cnt;
        repeat (256) pbit(1'b1, 1'b0);
        lb_read(8'h04, rd); check("err_255", rd, 32'h0000FF02);
        repeat (45) pbit(1'b1, 1'b0);
        lb_read(8'h04, rd); check("err_sat", rd, 32'h0000FF02);
        check("err_no_rx", 32'(rx_cnt - rx0), 32'd0);
        lb_write(8'h08, 32'h0);
        lb_read(8'h04, rd); check("err_clr", rd, 32'h00000002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
